// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared encodings for the 8-bit RISC write-back path:
//   - write-back mux select values (MD_F, MD_DOUT, MD_Y)
//   - decoded instruction classes (opc_e)
//   - write-back sequencer states (wb_state_e)
//   - opc_to_md(): instruction class -> write-back mux select
// -----------------------------------------------------------------------------
package risc_pkg;

    // Write-back mux select. 2'b11 is not a legal select and is never produced.
    localparam logic [1:0] MD_F    = 2'b00;
    localparam logic [1:0] MD_DOUT = 2'b01;
    localparam logic [1:0] MD_Y    = 2'b10;

    typedef enum logic [1:0] {
        OPC_ALU  = 2'b00,
        OPC_LOAD = 2'b01,
        OPC_MOVY = 2'b10,
        OPC_NOWB = 2'b11
    } opc_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_EXEC     = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_WB       = 2'b11
    } wb_state_e;

    // NOWB never reaches the write-back state; it maps to MD_F only so the
    // function is total and can never return the illegal 2'b11.
    function automatic logic [1:0] opc_to_md(opc_e opc);
        logic [1:0] md;
        unique case (opc)
            OPC_LOAD: md = MD_DOUT;
            OPC_MOVY: md = MD_Y;
            default:  md = MD_F;
        endcase
        return md;
    endfunction

endpackage

// File: rtl/wb_tmo_cnt.sv
// -----------------------------------------------------------------------------
// wb_tmo_cnt
// Load-timeout counter for wb_sequencer. Counts enabled cycles since the last
// clear and flags expiry on the LIMIT-th enabled cycle.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   clr_i      synchronous clear (dominates enable)
//   en_i       count this cycle
//   expired_o  LIMIT enabled cycles have elapsed since the clear
// -----------------------------------------------------------------------------
module wb_tmo_cnt #(
    parameter  int unsigned LIMIT = 15,
    localparam int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of enabled cycles already completed, so the
    // cycle that completes the LIMIT-th one is the one with cnt_q == LIMIT-1.
    assign expired_o = (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_sequencer.sv
// -----------------------------------------------------------------------------
// wb_sequencer
// Multi-cycle controller for the register-file write-back path. Accepts one
// decoded instruction at a time, runs the memory read handshake for loads and
// drives the write-back mux select (MD) and the register-file write strobe.
// All outputs are registered.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   instr_vld       decoder offers an instruction
//   instr_ack       1-cycle pulse, instruction accepted
//   op_class        00 ALU, 01 LOAD, 10 MOVY, 11 NOWB
//   rd_in           destination register of the offered instruction
//   mem_rd          memory read request, held until mem_rdy
//   mem_rdy         memory read data valid
//   MD              write-back mux select (00 F, 01 data_out, 10 Y)
//   rf_we, rf_wa    register-file write strobe / address
//   busy            sequencer not idle
//   err             sticky load-timeout flag
//
// Build option: define WB_TIMEOUT_EN to abort a load after TMO_CYCLES cycles
// in MEM_WAIT without mem_rdy (err set, no write). Without it MEM_WAIT waits
// indefinitely and err is tied low.
// -----------------------------------------------------------------------------
module wb_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned RA_W       = 3,
    parameter int unsigned TMO_CYCLES = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_vld,
    output logic            instr_ack,
    input  logic [1:0]      op_class,
    input  logic [RA_W-1:0] rd_in,
    output logic            mem_rd,
    input  logic            mem_rdy,
    output logic [1:0]      MD,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_wa,
    output logic            busy,
    output logic            err
);

    if (TMO_CYCLES < 1) begin : g_tmo_chk
        $error("wb_sequencer: TMO_CYCLES must be at least 1");
    end

    wb_state_e       state_q, state_d;
    opc_e            opc_q, opc_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic            instr_ack_q, instr_ack_d;
    logic            mem_rd_q, mem_rd_d;
    logic [1:0]      md_q, md_d;
    logic            rf_we_q, rf_we_d;
    logic [RA_W-1:0] rf_wa_q, rf_wa_d;
    logic            busy_q, busy_d;
    logic            tmo_expired;
    logic            tmo_fire;

`ifdef WB_TIMEOUT_EN
    logic err_q;

    wb_tmo_cnt #(.LIMIT(TMO_CYCLES)) u_tmo_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != S_MEM_WAIT),
        .en_i      (state_q == S_MEM_WAIT),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (tmo_fire)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign tmo_expired = 1'b0;
    assign err         = 1'b0;
`endif

    // mem_rdy arriving on the expiry edge wins over the timeout.
    assign tmo_fire = (state_q == S_MEM_WAIT) && !mem_rdy && tmo_expired;

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opc_q       <= OPC_ALU;
            rd_q        <= '0;
            instr_ack_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            md_q        <= MD_F;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            rd_q        <= rd_d;
            instr_ack_q <= instr_ack_d;
            mem_rd_q    <= mem_rd_d;
            md_q        <= md_d;
            rf_we_q     <= rf_we_d;
            rf_wa_q     <= rf_wa_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (instr_vld) state_d = S_EXEC;
            S_EXEC: begin
                unique case (opc_q)
                    OPC_LOAD: state_d = S_MEM_WAIT;
                    OPC_NOWB: state_d = S_IDLE;
                    default:  state_d = S_WB;
                endcase
            end
            S_MEM_WAIT: begin
                if (mem_rdy)       state_d = S_WB;
                else if (tmo_fire) state_d = S_IDLE;
            end
            S_WB:       state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output logic. The write strobe and MD are registered from the WB state,
    // so both change on the same edge and rf_we lands two edges after accept.
    always_comb begin
        opc_d       = opc_q;
        rd_d        = rd_q;
        instr_ack_d = 1'b0;
        md_d        = md_q;
        rf_wa_d     = rf_wa_q;
        rf_we_d     = 1'b0;

        if (state_q == S_IDLE && instr_vld) begin
            opc_d       = opc_e'(op_class);
            rd_d        = rd_in;
            instr_ack_d = 1'b1;
        end

        if (state_q == S_WB) begin
            md_d    = opc_to_md(opc_q);
            rf_wa_d = rd_q;
            rf_we_d = 1'b1;
        end

        mem_rd_d = (state_d == S_MEM_WAIT);
        busy_d   = (state_d != S_IDLE);
    end

    assign instr_ack = instr_ack_q;
    assign mem_rd    = mem_rd_q;
    assign MD        = md_q;
    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign busy      = busy_q;

endmodule
